// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, address decode helper and
// the state encoding of the single-outstanding master.
package axi4_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_WADDR_DATA = 3'd1;
  localparam logic [2:0] ST_WRESP      = 3'd2;
  localparam logic [2:0] ST_RADDR      = 3'd3;
  localparam logic [2:0] ST_RDATA      = 3'd4;
  localparam logic [2:0] ST_RSP        = 3'd5;

  typedef enum logic [2:0] {
    IDLE       = ST_IDLE,
    WADDR_DATA = ST_WADDR_DATA,
    WRESP      = ST_WRESP,
    RADDR      = ST_RADDR,
    RDATA      = ST_RDATA,
    RSP        = ST_RSP
  } state_e;

  // Lowest address bit that selects a register word for a given bus width.
  function automatic int unsigned addr_lsb(input int unsigned data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/axi4_lite_valid_hold.sv
// One AXI VALID flag: set by start, held until the cycle after VALID&&READY,
// so VALID is never withdrawn before its handshake.
module axi4_lite_valid_hold (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic ready,
  output logic valid
);

  logic valid_d;
  logic valid_q;

  always_comb begin
    // NOTE: default every combinational output first so no branch leaves it unassigned (no latch).
    valid_d = valid_q;
    if (valid_q && ready) begin
      valid_d = 1'b0;
    end else if (start) begin
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_n) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
    end
  end

  assign valid = valid_q;

endmodule

// File: rtl/axi4_lite_master.sv
// Single-outstanding AXI4-Lite initiator: turns a cmd/rsp handshake into one
// AXI4-Lite read or write at a time, with every bus and response output registered.
module axi4_lite_master
  import axi4_lite_pkg::*;
#(
  parameter int ADDRESS    = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                      ACLK,
  input  logic                      ARESETN,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [ADDRESS-1:0]        cmd_addr,
  input  logic [DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic                      rsp_write,
  output logic [DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                rsp_resp,
  output logic [ADDRESS-1:0]        M_AWADDR,
  output logic                      M_AWVALID,
  input  logic                      M_AWREADY,
  output logic [DATA_WIDTH-1:0]     M_WDATA,
  output logic [DATA_WIDTH/8-1:0]   M_WSTRB,
  output logic                      M_WVALID,
  input  logic                      M_WREADY,
  input  logic [1:0]                M_BRESP,
  input  logic                      M_BVALID,
  output logic                      M_BREADY,
  output logic [ADDRESS-1:0]        M_ARADDR,
  output logic                      M_ARVALID,
  input  logic                      M_ARREADY,
  input  logic [DATA_WIDTH-1:0]     M_RDATA,
  input  logic [1:0]                M_RRESP,
  input  logic                      M_RVALID,
  output logic                      M_RREADY
);

  localparam int STRB_W = DATA_WIDTH / 8;

  state_e              state_d,     state_q;
  logic [ADDRESS-1:0]  awaddr_d,    awaddr_q;
  logic [DATA_WIDTH-1:0] wdata_d,   wdata_q;
  logic [STRB_W-1:0]   wstrb_d,     wstrb_q;
  logic [ADDRESS-1:0]  araddr_d,    araddr_q;
  logic                bready_d,    bready_q;
  logic                rready_d,    rready_q;
  logic                aw_done_d,   aw_done_q;
  logic                w_done_d,    w_done_q;
  logic                rsp_valid_d, rsp_valid_q;
  logic                rsp_write_d, rsp_write_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_d, rsp_rdata_q;
  logic [1:0]          rsp_resp_d,  rsp_resp_q;

  logic cmd_accept;
  logic aw_hs;
  logic w_hs;
  logic ar_hs;
  logic aw_seen;
  logic w_seen;

  assign cmd_ready  = (state_q == IDLE);
  assign cmd_accept = cmd_valid && cmd_ready;
  assign aw_hs      = M_AWVALID && M_AWREADY;
  assign w_hs       = M_WVALID && M_WREADY;
  assign ar_hs      = M_ARVALID && M_ARREADY;

  // AW and W complete independently; remember whichever finished first.
  assign aw_seen = aw_done_q || aw_hs;
  assign w_seen  = w_done_q || w_hs;

  axi4_lite_valid_hold u_aw_valid (
    .clk   (ACLK),
    .rst_n (ARESETN),
    .start (cmd_accept && cmd_write),
    .ready (M_AWREADY),
    .valid (M_AWVALID)
  );

  axi4_lite_valid_hold u_w_valid (
    .clk   (ACLK),
    .rst_n (ARESETN),
    .start (cmd_accept && cmd_write),
    .ready (M_WREADY),
    .valid (M_WVALID)
  );

  axi4_lite_valid_hold u_ar_valid (
    .clk   (ACLK),
    .rst_n (ARESETN),
    .start (cmd_accept && !cmd_write),
    .ready (M_ARREADY),
    .valid (M_ARVALID)
  );

  always_comb begin
    state_d     = state_q;
    awaddr_d    = awaddr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    araddr_d    = araddr_q;
    bready_d    = bready_q;
    rready_d    = rready_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    rsp_valid_d = rsp_valid_q;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;

    unique case (state_q)
      IDLE: begin
        if (cmd_accept) begin
          if (cmd_write) begin
            awaddr_d = cmd_addr;
            wdata_d  = cmd_wdata;
            wstrb_d  = cmd_wstrb;
            state_d  = WADDR_DATA;
          end else begin
            araddr_d = cmd_addr;
            state_d  = RADDR;
          end
        end
      end

      WADDR_DATA: begin
        aw_done_d = aw_seen;
        w_done_d  = w_seen;
        if (aw_seen && w_seen) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          bready_d  = 1'b1;
          state_d   = WRESP;
        end
      end

      WRESP: begin
        if (M_BVALID && bready_q) begin
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_resp_d  = M_BRESP;
          state_d     = RSP;
        end
      end

      RADDR: begin
        if (ar_hs) begin
          rready_d = 1'b1;
          state_d  = RDATA;
        end
      end

      RDATA: begin
        if (M_RVALID && rready_q) begin
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b0;
          rsp_rdata_d = M_RDATA;
          rsp_resp_d  = M_RRESP;
          state_d     = RSP;
        end
      end

      RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q     <= IDLE;
      awaddr_q    <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      araddr_q    <= '0;
      bready_q    <= 1'b0;
      rready_q    <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= RESP_OKAY;
    end else begin
      state_q     <= state_d;
      awaddr_q    <= awaddr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      araddr_q    <= araddr_d;
      bready_q    <= bready_d;
      rready_q    <= rready_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
    end
  end

  assign M_AWADDR  = awaddr_q;
  assign M_WDATA   = wdata_q;
  assign M_WSTRB   = wstrb_q;
  assign M_ARADDR  = araddr_q;
  assign M_BREADY  = bready_q;
  assign M_RREADY  = rready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_write_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_resp  = rsp_resp_q;

endmodule

// File: doc/axi4_lite_master.md
Name: axi4_lite_master

Overview:
- Single-outstanding AXI4-Lite initiator that converts a simple command/response handshake into AXI4-Lite read and write transactions.
- Used by local controllers and testbenches to drive axi4_lite_slave register banks.
- Issues AW and W together.
- Accepts AW/W readiness in any order and returns BRESP, or RDATA plus RRESP, on a response port.

Parameters:
ADDRESS, 32, AXI address width
DATA_WIDTH, 32, data width (8/16/32/64)

Ports:
ACLK  input  1  clock
ARESETN  input  1  asynchronous active-low reset
cmd_valid  input  1  command request
cmd_ready  output  1  command accepted when high with cmd_valid
cmd_write  input  1  1=write, 0=read
cmd_addr  input  ADDRESS  byte address
cmd_wdata  input  DATA_WIDTH  write data
cmd_wstrb  input  DATA_WIDTH/8  write strobes
rsp_valid  output  1  response available
rsp_ready  input  1  response consumed
rsp_write  output  1  response belongs to a write
rsp_rdata  output  DATA_WIDTH  read data (0 for writes)
rsp_resp  output  2  BRESP/RRESP
M_AWADDR  output  ADDRESS
M_AWVALID  output  1
M_AWREADY  input  1
M_WDATA  output  DATA_WIDTH
M_WSTRB  output  DATA_WIDTH/8
M_WVALID  output  1
M_WREADY  input  1
M_BRESP  input  2
M_BVALID  input  1
M_BREADY  output  1
M_ARADDR  output  ADDRESS
M_ARVALID  output  1
M_ARREADY  input  1
M_RDATA  input  DATA_WIDTH
M_RRESP  input  2
M_RVALID  input  1
M_RREADY  output  1

Behaviour:
- Clock ACLK; reset ARESETN, asynchronous, active-low.
- Reset values:
  - All VALID/READY outputs 0.
  - All address, data, strobe and resp outputs 0.
  - State IDLE.
- All AXI and rsp outputs are registered. No combinational path from any input to any AXI output.
- States: IDLE, WADDR_DATA, WRESP, RADDR, RDATA, RSP.
- cmd_ready = (state==IDLE). A command is accepted on cmd_valid&&cmd_ready; the bus fields are captured that cycle.
- Write path:
  - Acceptance -> WADDR_DATA. M_AWVALID and M_WVALID rise the following cycle, with M_AWADDR/M_WDATA/M_WSTRB stable.
  - Each VALID drops independently the cycle after its own handshake (VALID&&READY). The order is arbitrary; both in the same cycle is legal.
  - Once both handshakes are done -> WRESP, M_BREADY=1.
  - On M_BVALID&&M_BREADY: capture M_BRESP, M_BREADY=0 -> RSP.
- Read path:
  - Acceptance -> RADDR. M_ARVALID rises the next cycle and drops after the M_ARREADY handshake -> RDATA, M_RREADY=1.
  - On M_RVALID&&M_RREADY: capture M_RDATA/M_RRESP, M_RREADY=0 -> RSP.
- RSP:
  - rsp_valid=1; rsp_write/rsp_rdata/rsp_resp held stable until rsp_ready.
  - On the handshake: rsp_valid=0 -> IDLE. The next command can be accepted the following cycle.
- VALID signals are never withdrawn before their handshake, regardless of READY timing. No timeout.
- Minimum write latency from command acceptance to rsp_valid: 4 cycles when slave READYs are high. Read: same, 4 cycles.
- rsp_resp is passed through unmodified: OKAY=2'b00, SLVERR=2'b10.
- Reset mid-transaction: all VALID/READY outputs are forced low immediately and the transaction is discarded. No response is generated.
- cmd_* fields are ignored outside an accept cycle.
- Misalignment and range are not checked locally; the slave reports them.

Decomposition:
- Shared package axi4_lite_pkg:
  - RESP_OKAY/EXOKAY/SLVERR/DECERR constants.
  - ADDR_LSB function, also used by axi4_lite_slave.
  - State encoding localparams.
- Sub-module axi4_lite_valid_hold: a one-bit VALID register that sets on start and clears on VALID&&READY. Instantiated for AW, W and AR.

Test Plan:
- Paired with axi4_lite_slave (REG_COUNT 32): write 0x10 data 0xDEADBEEF strb 0xF -> rsp_write=1, rsp_resp=00; then read 0x10 -> rsp_rdata=0xDEADBEEF, rsp_resp=00.
- Partial strobe: write 0x10 data 0x11223344 strb 0x3 after the first test -> read returns 0xDEAD3344.
- Misaligned write 0x02 -> rsp_resp=10; read of 0x7C (index 31) -> 00; read of 0x80 when ADDRESS>7 bits wraps per slave decode, and the observed resp must match the slave model.
- Skewed handshakes (stub slave): M_WREADY high 3 cycles before M_AWREADY -> M_WVALID drops first, M_AWVALID stays high, exactly one B handshake, then rsp_valid. Reverse order also checked.
- Backpressure: rsp_ready low for 5 cycles -> rsp_valid and data stable, cmd_ready=0. A new cmd_valid is not accepted until the cycle after rsp_ready.
- ARESETN asserted while M_AWVALID=1 -> all VALID/READY outputs 0 in the same cycle, rsp_valid=0. After release, cmd_ready=1 and a fresh write completes normally.
